lsu_master: RTL and testbench
=============================

# lsu_master

Initiator-side load/store unit between the pipeline MEM stage and a word-wide, handshaked data memory bus. It accepts one load or store per transaction and converts the byte address and access type into aligned bus cycles with byte enables. For loads it extracts the addressed lanes from the returned word and sign- or zero-extends them. Misaligned word and halfword accesses are split into two sequential bus cycles, or rejected with an error when splitting is disabled.

## Interface
- SPLIT_EN, 1, 1: misaligned accesses are split into two bus cycles; 0: misaligned accesses are rejected with resp_err.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered by the pipeline.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  access type: 000 W, 010 H, 011 HU, 100 B, 101 BU; stores treat HU as H and BU as B.
- req_addr  in  32  byte address.
- req_wd  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rd  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; request was illegal.
- bus_req  out  1  bus cycle request.
- bus_gnt  in  1  bus accepts the cycle when bus_req && bus_gnt.
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned address, bits [1:0] = 0.
- bus_be  out  4  byte enables; bit i selects bits 8i+7:8i (little-endian).
- bus_wd  out  32  lane-positioned write data.
- bus_rvalid  in  1  read data valid; arrives one or more cycles after read acceptance.
- bus_rd  in  32  read data.

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: req_ready = 1. On req_valid, latch we, type, addr, wd, and off = addr[1:0].
  - Illegal types (001, 110, 111) go to RESP with err = 1.
  - Misaligned requests with SPLIT_EN = 0 also go to RESP with err = 1.
  - All other requests go to ISSUE0.
- Misaligned means: W with off ≠ 0, or H/HU with off odd.
- Access size sz: W = 4, H = 2, B = 1.
- Lane generation uses 64-bit intermediates:
  - mask64 = ((1<<sz)-1) << off.
  - data64 = {32'b0, wd} << 8·off.
- Access 0: addr = {a[31:2], 2'b00}, be = mask64[3:0], wd = data64[31:0].
- Access 1: required only when mask64[7:4] ≠ 0; addr = access 0 addr + 4, be = mask64[7:4], wd = data64[63:32].
- ISSUEn: assert bus_req with stable address, be, we, and wd until bus_gnt.
  - For a store, bus_gnt completes the cycle: go to ISSUE1 if access 1 is required, otherwise RESP.
  - For a load, go to WAITn.
- WAITn: hold until bus_rvalid, then capture bus_rd into rd0 or rd1. Go to ISSUE1 or RESP.
- Load result: r = ({rd1, rd0} >> 8·off)[31:0].
  - W: r.
  - H: sign-extend r[15:0]; HU: zero-extend r[15:0].
  - B: sign-extend r[7:0]; BU: zero-extend r[7:0].
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- bus_rvalid outside WAITn is ignored.

## Timing
- Reset (asynchronous, active-low) forces:
  - state IDLE, req_ready = 1;
  - bus_req, bus_we, bus_be, bus_addr, bus_wd, resp_valid, resp_err, resp_rd all 0;
  - rd0 and rd1 cleared.
- Reset in any state aborts the transaction with no response. Any late bus_rvalid after reset is ignored.
- All bus and response outputs are registered and driven directly from state and latched registers.
- Aligned store with bus_gnt tied high:
  - accept at cycle 0;
  - bus_req at cycle 1;
  - resp_valid at cycle 2.
- Aligned load with gnt = 1 and rvalid one cycle after acceptance: resp_valid at cycle 3.
- Split access adds one ISSUE cycle, plus one WAIT cycle for loads.
- Error response: resp_valid one cycle after acceptance, with no bus_req.
- Throughput: the next request is accepted at the earliest in the cycle after RESP.

## Structure
- Shared header macro.vh holds:
  - type codes: TYPE_W, TYPE_H, TYPE_HU, TYPE_B, TYPE_BU;
  - state encodings;
  - existing Word, Half, and Byte field macros.
- Combinational sub-module lane_align computes mask64, data64, the access-1-required flag, the misaligned flag, and load extraction/extension. lsu_master holds the FSM and registers.

## Test plan
- Store W 0x11223344 at 0x100, gnt = 1 → one bus cycle: addr 0x100, be 1111, wd 0x11223344; resp_valid at cycle 2 with err = 0.
- Load B at 0x103, bus_rd = 0x80FFFFFF → be 1000, resp_rd = 0xFFFFFF80. Load BU at the same address → resp_rd = 0x00000080.
- Store H 0xBEEF at 0x203, SPLIT_EN = 1 → first cycle: addr 0x200, be 1000, wd 0xEF000000. Second cycle: addr 0x204, be 0001, wd 0x000000BE.
- Load W at 0x302, rd0 = 0xAABBCCDD, rd1 = 0x11223344, gnt stalled 3 cycles per access → bus_req held stable while stalled; resp_rd = 0x3344AABB.
- SPLIT_EN = 0: load W at 0x001 → no bus_req; next cycle resp_valid = 1, resp_err = 1, resp_rd = 0. Type 110 gives the same response.
- Reset asserted in WAIT0, then rvalid pulses after release → outputs 0 during reset; IDLE after release; no resp_valid.

Source files
------------

// File: rtl/lsu_master_pkg.sv
// lsu_master_pkg: shared definitions for the load/store unit.
//   - access type codes (W, H, HU, B, BU)
//   - FSM state encoding
//   - word/half/byte field widths and helper functions for byte-lane masks
`timescale 1ns/1ps
package lsu_master_pkg;

  localparam logic [2:0] TYPE_W  = 3'b000;
  localparam logic [2:0] TYPE_H  = 3'b010;
  localparam logic [2:0] TYPE_HU = 3'b011;
  localparam logic [2:0] TYPE_B  = 3'b100;
  localparam logic [2:0] TYPE_BU = 3'b101;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_WAIT0  = 3'd2,
    S_ISSUE1 = 3'd3,
    S_WAIT1  = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  // Unshifted byte-enable pattern for the access size (W = 4, H = 2, B = 1).
  function automatic logic [3:0] size_mask(input logic [2:0] typ);
    case (typ)
      TYPE_W:          return 4'b1111;
      TYPE_H, TYPE_HU: return 4'b0011;
      default:         return 4'b0001;
    endcase
  endfunction

  function automatic logic type_legal(input logic [2:0] typ);
    return (typ == TYPE_W) || (typ == TYPE_H) || (typ == TYPE_HU) ||
           (typ == TYPE_B) || (typ == TYPE_BU);
  endfunction

endpackage

// File: rtl/lsu_master_lane_align.sv
// lane_align: combinational byte-lane steering for lsu_master.
//   typ, off      access type and byte offset within the word
//   wd            right-justified store data
//   rd0, rd1      read words of access 0 and access 1
//   mask          8-bit lane mask over two consecutive words
//   data          store data positioned across two words
//   need1         a second bus access is required
//   misaligned    W with off != 0, or H/HU with odd off
//   illegal       unsupported type code
//   ext           extracted and sign/zero-extended load result
`timescale 1ns/1ps
module lane_align
  import lsu_master_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] rd0,
  input  logic [31:0] rd1,
  output logic [7:0]  mask,
  output logic [63:0] data,
  output logic        need1,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] ext
);

  logic [63:0] rd_cat;
  logic [31:0] r;

  always_comb begin
    mask       = {4'b0000, size_mask(typ)} << off;
    data       = {32'h0, wd} << {off, 3'b000};
    need1      = |mask[7:4];
    misaligned = ((typ == TYPE_W) && (off != 2'b00)) ||
                 (((typ == TYPE_H) || (typ == TYPE_HU)) && off[0]);
    illegal    = !type_legal(typ);
    // rd1 only contributes bytes for accesses that spill into the next word.
    rd_cat     = {rd1, rd0} >> {off, 3'b000};
    r          = rd_cat[WORD_W-1:0];
    case (typ)
      TYPE_H:  ext = {{(WORD_W-HALF_W){r[HALF_W-1]}}, r[HALF_W-1:0]};
      TYPE_HU: ext = {{(WORD_W-HALF_W){1'b0}}, r[HALF_W-1:0]};
      TYPE_B:  ext = {{(WORD_W-BYTE_W){r[BYTE_W-1]}}, r[BYTE_W-1:0]};
      TYPE_BU: ext = {{(WORD_W-BYTE_W){1'b0}}, r[BYTE_W-1:0]};
      default: ext = r;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// lsu_master: initiator-side load/store unit, MEM stage to word-wide bus.
//   clk, reset          clock, asynchronous active-low reset
//   req_*               request handshake from the pipeline (ready only in IDLE)
//   resp_*              one-cycle completion pulse with load data / error
//   bus_*               handshaked word bus (req/gnt, rvalid for read data)
// Misaligned accesses become two bus cycles when SPLIT_EN = 1, else errors.
// All bus and response outputs are registered.
`timescale 1ns/1ps
module lsu_master
  import lsu_master_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic        resp_valid,
  output logic [31:0] resp_rd,
  output logic        resp_err,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wd,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rd
);

  state_t      state, state_n;
  logic        we_q;
  logic [2:0]  typ_q;
  logic [31:0] addr_q, wd_q;
  logic        err_q, err_n;
  logic [31:0] rd0, rd1, rd0_n, rd1_n;

  logic        cur_we;
  logic [2:0]  cur_typ;
  logic [31:0] cur_addr, cur_wd, base_addr;

  logic [7:0]  mask;
  logic [63:0] data;
  logic        need1, misaligned, illegal;
  logic [31:0] ext;

  logic        bus_req_n, bus_we_n, resp_valid_n, resp_err_n;
  logic [31:0] bus_addr_n, bus_wd_n, resp_rd_n;
  logic [3:0]  bus_be_n;

  // In IDLE the live request drives lane steering so the first bus cycle
  // can be registered on the accepting edge; afterwards the latched copy does.
  always_comb begin
    if (state == S_IDLE) begin
      cur_we   = req_we;
      cur_typ  = req_type;
      cur_addr = req_addr;
      cur_wd   = req_wd;
    end else begin
      cur_we   = we_q;
      cur_typ  = typ_q;
      cur_addr = addr_q;
      cur_wd   = wd_q;
    end
  end

  lane_align u_align (
    .typ        (cur_typ),
    .off        (cur_addr[1:0]),
    .wd         (cur_wd),
    .rd0        (rd0_n),
    .rd1        (rd1_n),
    .mask       (mask),
    .data       (data),
    .need1      (need1),
    .misaligned (misaligned),
    .illegal    (illegal),
    .ext        (ext)
  );

  always_comb begin
    state_n      = state;
    err_n        = err_q;
    rd0_n        = rd0;
    rd1_n        = rd1;
    base_addr    = {cur_addr[31:2], 2'b00};
    bus_req_n    = 1'b0;
    bus_we_n     = 1'b0;
    bus_addr_n   = 32'h0;
    bus_be_n     = 4'h0;
    bus_wd_n     = 32'h0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal || (misaligned && !SPLIT_EN)) begin
            state_n = S_RESP;
            err_n   = 1'b1;
          end else begin
            state_n = S_ISSUE0;
            err_n   = 1'b0;
          end
        end
      end
      S_ISSUE0: begin
        if (bus_gnt) state_n = cur_we ? (need1 ? S_ISSUE1 : S_RESP) : S_WAIT0;
      end
      S_WAIT0: begin
        if (bus_rvalid) begin
          rd0_n   = bus_rd;
          state_n = need1 ? S_ISSUE1 : S_RESP;
        end
      end
      S_ISSUE1: begin
        if (bus_gnt) state_n = cur_we ? S_RESP : S_WAIT1;
      end
      S_WAIT1: begin
        if (bus_rvalid) begin
          rd1_n   = bus_rd;
          state_n = S_RESP;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Outputs are precomputed from the state being entered so they appear
    // registered in that state and stay stable while the bus stalls.
    if (state_n == S_ISSUE0) begin
      bus_req_n  = 1'b1;
      bus_we_n   = cur_we;
      bus_addr_n = base_addr;
      bus_be_n   = mask[3:0];
      bus_wd_n   = data[31:0];
    end else if (state_n == S_ISSUE1) begin
      bus_req_n  = 1'b1;
      bus_we_n   = cur_we;
      bus_addr_n = base_addr + 32'd4;
      bus_be_n   = mask[7:4];
      bus_wd_n   = data[63:32];
    end

    resp_valid_n = (state_n == S_RESP);
    resp_err_n   = resp_valid_n && err_n;
    resp_rd_n    = (resp_valid_n && !err_n && !cur_we) ? ext : 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      err_q      <= 1'b0;
      rd0        <= 32'h0;
      rd1        <= 32'h0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'h0;
      bus_wd     <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rd    <= 32'h0;
    end else begin
      state      <= state_n;
      req_ready  <= (state_n == S_IDLE);
      err_q      <= err_n;
      rd0        <= rd0_n;
      rd1        <= rd1_n;
      bus_req    <= bus_req_n;
      bus_we     <= bus_we_n;
      bus_addr   <= bus_addr_n;
      bus_be     <= bus_be_n;
      bus_wd     <= bus_wd_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rd    <= resp_rd_n;
    end
  end

  // Request fields are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      we_q   <= req_we;
      typ_q  <= req_type;
      addr_q <= req_addr;
      wd_q   <= req_wd;
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
`timescale 1ns/1ps
module tb_lsu_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wd;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rd;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wd, bus_rd;
  logic [3:0]  bus_be;

  logic        ns_req_valid, ns_req_ready, ns_req_we;
  logic [2:0]  ns_req_type;
  logic [31:0] ns_req_addr, ns_req_wd;
  logic        ns_resp_valid, ns_resp_err;
  logic [31:0] ns_resp_rd;
  logic        ns_bus_req, ns_bus_gnt, ns_bus_we, ns_bus_rvalid;
  logic [31:0] ns_bus_addr, ns_bus_wd, ns_bus_rd;
  logic [3:0]  ns_bus_be;

  lsu_master #(.SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wd(req_wd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wd(bus_wd),
    .bus_rvalid(bus_rvalid), .bus_rd(bus_rd)
  );

  lsu_master #(.SPLIT_EN(1'b0)) u_ns (
    .clk(clk), .reset(reset),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we),
    .req_type(ns_req_type), .req_addr(ns_req_addr), .req_wd(ns_req_wd),
    .resp_valid(ns_resp_valid), .resp_rd(ns_resp_rd), .resp_err(ns_resp_err),
    .bus_req(ns_bus_req), .bus_gnt(ns_bus_gnt), .bus_we(ns_bus_we),
    .bus_addr(ns_bus_addr), .bus_be(ns_bus_be), .bus_wd(ns_bus_wd),
    .bus_rvalid(ns_bus_rvalid), .bus_rd(ns_bus_rd)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } bus_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
    int          lat;
  } resp_t;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int gnt_delay = 0;
  int rv_extra  = 0;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];
  logic [31:0] mem [logic [31:0]];

  bus_t        m_acc0, m_acc1, mb;
  resp_t       mr;
  int          m_n, m_lat;
  logic [31:0] m_rd;
  logic        m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    int lane;
    w    = mem_word(a);
    lane = int'(a[1:0]);
    return w[8*lane +: 8];
  endfunction

  // Bus slave: grants after gnt_delay stall cycles, returns read data
  // rv_extra cycles after the cycle following acceptance.
  initial begin
    int stall, pend;
    logic req_last, we_last;
    logic [31:0] addr_last, pend_addr;
    stall = 0; pend = 0; req_last = 1'b0; we_last = 1'b0;
    addr_last = 32'h0; pend_addr = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rd = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus_rvalid = 1'b1;
          bus_rd     = mem_word(pend_addr);
        end
      end
      if (req_last && bus_gnt && !we_last) begin
        if (rv_extra == 0) begin
          bus_rvalid = 1'b1;
          bus_rd     = mem_word(addr_last);
        end else begin
          pend      = rv_extra;
          pend_addr = addr_last;
        end
      end
      if (bus_req) begin
        if (stall < gnt_delay) begin
          bus_gnt = 1'b0;
          stall++;
        end else begin
          bus_gnt = 1'b1;
          stall   = 0;
        end
      end else begin
        bus_gnt = 1'b0;
        stall   = 0;
      end
      req_last  = bus_req;
      we_last   = bus_we;
      addr_last = bus_addr;
    end
  end

  // Compare process for the split-enabled unit.
  int   acc_cyc = 0;
  logic prev_stall = 1'b0;
  bus_t prev;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (prev_stall) begin
        check("stall_req_held", bus_req, 1);
        check("stall_addr_held", bus_addr, prev.addr);
        check("stall_be_held", bus_be, prev.be);
        check("stall_wd_held", bus_wd, prev.wd);
        check("stall_we_held", bus_we, prev.we);
      end
      if (bus_req && bus_gnt) begin
        if (exp_bus.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_bus_cycle: addr 0x%0h be 0x%0h, none expected", bus_addr, bus_be);
        end else begin
          mb = exp_bus.pop_front();
          check("bus_we", bus_we, mb.we);
          check("bus_addr", bus_addr, mb.addr);
          check("bus_be", bus_be, mb.be);
          if (mb.we) check("bus_wd", bus_wd, mb.wd);
        end
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_resp: rd 0x%0h err %0d, none expected", resp_rd, resp_err);
        end else begin
          mr = exp_resp.pop_front();
          check("resp_err", resp_err, mr.err);
          check("resp_rd", resp_rd, mr.rd);
          check("resp_latency", 64'(cyc - acc_cyc), 64'(mr.lat));
        end
      end
      prev_stall = bus_req && !bus_gnt;
      prev.we    = bus_we;
      prev.addr  = bus_addr;
      prev.be    = bus_be;
      prev.wd    = bus_wd;
    end
  end

  // Model: walk the accessed bytes one at a time, assign each to its word
  // and lane, gather load bytes from memory, then extend by type.
  task automatic model_req(input logic we, input logic [2:0] typ,
                           input logic [31:0] addr, input logic [31:0] wd);
    bus_t acc [2];
    resp_t r;
    int sz, n;
    logic [31:0] base, v;
    logic legal;
    legal = (typ == 3'b000) || (typ == 3'b010) || (typ == 3'b011) ||
            (typ == 3'b100) || (typ == 3'b101);
    sz    = (typ == 3'b000) ? 4 : ((typ == 3'b010 || typ == 3'b011) ? 2 : 1);
    base  = {addr[31:2], 2'b00};
    n = 0; v = 32'h0;
    r.err = 1'b0; r.rd = 32'h0; r.lat = 1;
    for (int i = 0; i < 2; i++) begin
      acc[i].we   = we;
      acc[i].addr = base + 32'(4 * i);
      acc[i].be   = 4'h0;
      acc[i].wd   = 32'h0;
    end
    if (!legal) begin
      r.err = 1'b1;
    end else begin
      for (int k = 0; k < sz; k++) begin
        logic [31:0] ba;
        int idx, lane;
        ba   = addr + 32'(k);
        idx  = (ba[31:2] == base[31:2]) ? 0 : 1;
        lane = int'(ba[1:0]);
        acc[idx].be[lane]         = 1'b1;
        acc[idx].wd[8*lane +: 8]  = wd[8*k +: 8];
        v[8*k +: 8]               = mem_byte(ba);
        if (idx + 1 > n) n = idx + 1;
      end
      if (!we) begin
        case (typ)
          3'b000:  r.rd = v;
          3'b010:  r.rd = {{16{v[15]}}, v[15:0]};
          3'b011:  r.rd = {16'h0, v[15:0]};
          3'b100:  r.rd = {{24{v[7]}}, v[7:0]};
          default: r.rd = {24'h0, v[7:0]};
        endcase
      end
      r.lat = 1 + n * (gnt_delay + 1) + (we ? 0 : n * (1 + rv_extra));
      for (int i = 0; i < n; i++) exp_bus.push_back(acc[i]);
    end
    exp_resp.push_back(r);
    m_acc0 = acc[0]; m_acc1 = acc[1]; m_n = n; m_rd = r.rd; m_err = r.err; m_lat = r.lat;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] typ,
                           input logic [31:0] addr, input logic [31:0] wd);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("req_ready_before_issue", req_ready, 1);
    req_we = we; req_type = typ; req_addr = addr; req_wd = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input logic we, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wd);
    int t;
    model_req(we, typ, addr, wd);
    drive_req(we, typ, addr, wd);
    t = 0;
    while (exp_resp.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (exp_resp.size() != 0) begin
      fails++;
      $display("FAIL resp_timeout: %0d responses outstanding after %0d cycles, expected 0", exp_resp.size(), t);
      exp_resp.delete();
      exp_bus.delete();
    end
  endtask

  task automatic ns_req(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                        input logic exp_err, input int lat);
    logic saw;
    saw = 1'b0;
    @(posedge clk); #1;
    check("ns_req_ready", ns_req_ready, 1);
    ns_req_we = we; ns_req_type = typ; ns_req_addr = addr; ns_req_wd = 32'hCAFEF00D;
    ns_req_valid = 1'b1;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (ns_bus_req) saw = 1'b1;
      if (c < lat) check("ns_early_resp", ns_resp_valid, 0);
    end
    check("ns_resp_valid", ns_resp_valid, 1);
    check("ns_resp_err", ns_resp_err, exp_err);
    check("ns_resp_rd", ns_resp_rd, 0);
    check("ns_bus_req_seen", saw, !exp_err);
    @(negedge clk);
    check("ns_resp_one_cycle", ns_resp_valid, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_bus_we"}, bus_we, 0);
    check({tag, "_bus_be"}, bus_be, 0);
    check({tag, "_bus_addr"}, bus_addr, 0);
    check({tag, "_bus_wd"}, bus_wd, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_resp_rd"}, resp_rd, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000; req_addr = 32'h0; req_wd = 32'h0;
    ns_req_valid = 1'b0; ns_req_we = 1'b0; ns_req_type = 3'b000; ns_req_addr = 32'h0; ns_req_wd = 32'h0;
    ns_bus_gnt = 1'b1; ns_bus_rvalid = 1'b0; ns_bus_rd = 32'h0;
    mem[32'h100] = 32'h80FFFFFF;
    mem[32'h300] = 32'hAABBCCDD;
    mem[32'h304] = 32'h11223344;
    mem[32'h400] = 32'h12345678;

    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk); #2;
    reset = 1'b1;

    // Aligned word store, grant tied high.
    gnt_delay = 0; rv_extra = 0;
    run_req(1'b1, 3'b000, 32'h100, 32'h11223344);
    check("pin_sw_addr", m_acc0.addr, 32'h100);
    check("pin_sw_be", m_acc0.be, 4'b1111);
    check("pin_sw_wd", m_acc0.wd, 32'h11223344);
    check("pin_sw_lat", m_lat, 2);

    // Byte loads from the top lane.
    run_req(1'b0, 3'b100, 32'h103, 32'h0);
    check("pin_lb_rd", m_rd, 32'hFFFFFF80);
    check("pin_lb_be", m_acc0.be, 4'b1000);
    check("pin_lb_lat", m_lat, 3);
    run_req(1'b0, 3'b101, 32'h103, 32'h0);
    check("pin_lbu_rd", m_rd, 32'h00000080);

    // Halfword store straddling a word boundary.
    run_req(1'b1, 3'b010, 32'h203, 32'h0000BEEF);
    check("pin_sh_n", m_n, 2);
    check("pin_sh_addr0", m_acc0.addr, 32'h200);
    check("pin_sh_be0", m_acc0.be, 4'b1000);
    check("pin_sh_wd0", m_acc0.wd, 32'hEF000000);
    check("pin_sh_addr1", m_acc1.addr, 32'h204);
    check("pin_sh_be1", m_acc1.be, 4'b0001);
    check("pin_sh_wd1", m_acc1.wd, 32'h000000BE);
    check("pin_sh_lat", m_lat, 3);

    // Split word load with a 3-cycle grant stall on each access.
    gnt_delay = 3;
    run_req(1'b0, 3'b000, 32'h302, 32'h0);
    check("pin_lw_split_rd", m_rd, 32'h3344AABB);
    check("pin_lw_split_lat", m_lat, 11);
    gnt_delay = 0;

    // Odd halfword inside one word, byte store, split byte-free cases.
    run_req(1'b0, 3'b010, 32'h301, 32'h0);
    check("pin_lh_rd", m_rd, 32'hFFFFBBCC);
    run_req(1'b0, 3'b011, 32'h301, 32'h0);
    check("pin_lhu_rd", m_rd, 32'h0000BBCC);
    run_req(1'b1, 3'b100, 32'h102, 32'h0000005A);
    check("pin_sb_be", m_acc0.be, 4'b0100);
    check("pin_sb_wd", m_acc0.wd, 32'h005A0000);

    // Illegal types on the split-enabled unit.
    run_req(1'b0, 3'b001, 32'h100, 32'h0);
    check("pin_ill_err", m_err, 1);
    check("pin_ill_lat", m_lat, 1);
    run_req(1'b1, 3'b111, 32'h100, 32'h1);

    // Split disabled: misaligned and illegal are rejected, aligned still works.
    ns_req(1'b0, 3'b000, 32'h001, 1'b1, 1);
    ns_req(1'b0, 3'b110, 32'h000, 1'b1, 1);
    ns_req(1'b1, 3'b010, 32'h203, 1'b1, 1);
    ns_req(1'b1, 3'b000, 32'h100, 1'b0, 2);

    // Reset while waiting for read data; the late rvalid must be ignored.
    rv_extra = 6;
    exp_bus.push_back('{we: 1'b0, addr: 32'h400, be: 4'hF, wd: 32'h0});
    drive_req(1'b0, 3'b000, 32'h400, 32'h0);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_outputs_zero("post_abort");
    check("abort_bus_queue_empty", exp_bus.size(), 0);
    rv_extra = 0;

    // Normal operation resumes.
    run_req(1'b0, 3'b000, 32'h100, 32'h0);
    check("pin_lw_rd", m_rd, 32'h80FFFFFF);
    run_req(1'b0, 3'b100, 32'h302, 32'h0);
    check("pin_lb_neg_rd", m_rd, 32'hFFFFFFBB);

    check("final_bus_queue_empty", exp_bus.size(), 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, expected test to finish");
    $fatal(1, "timeout");
  end

endmodule
